// File: rtl/riot_6532.sv
// riot_6532: Atari 2600 RIOT (MOS 6532) bus responder with two I/O ports and the interval timer.
// Define RIOT_PA7_EDGE_EN to compile in the PA7 edge detector and its interrupt.
module riot_6532 #(
    parameter logic [7:0] RESET_TIMER = 8'h00
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ce,
    input  logic       cs,
    input  logic [4:0] addr,
    input  logic       we,
    input  logic [7:0] din,
    output logic [7:0] dout,
    input  logic [7:0] pa_in,
    input  logic [7:0] pb_in,
    output logic [7:0] pa_out,
    output logic [7:0] pb_out,
    output logic [7:0] pa_oe,
    output logic [7:0] pb_oe,
    output logic       irq_n
);
    logic [7:0] r_dout;
    logic [7:0] r_pa_out;
    logic [7:0] r_pa_oe;
    logic [7:0] r_pb_out;
    logic [7:0] r_pb_oe;
    logic [7:0] r_timer;
    logic [9:0] r_pre;
    logic [9:0] r_ivl_m1;
    logic       r_fast;
    logic       r_tflag;
    logic       r_tirq_en;
    logic       r_irq_n;

    logic [7:0] w_pa;
    logic [7:0] w_pb;
    logic [7:0] w_rdata;
    logic [9:0] w_ld_m1;
    logic       w_rd;
    logic       w_wr;
    logic       w_load;
    logic       w_intim_rd;
    logic       w_eflag;
    logic       w_eirq_en;

    assign w_pa       = (r_pa_out & r_pa_oe) | (pa_in & ~r_pa_oe);
    assign w_pb       = (r_pb_out & r_pb_oe) | (pb_in & ~r_pb_oe);
    assign w_rd       = cs & ce & ~we;
    assign w_wr       = cs & ce & we;
    assign w_load     = w_wr & addr[2] & addr[4];
    assign w_intim_rd = w_rd & addr[2] & ~addr[0];

    // Prescaler reload value is interval-1 for the 1T/8T/64T/1024T loads.
    always_comb begin
        w_ld_m1 = 10'd0;
        case (addr[1:0])
            2'd0: w_ld_m1 = 10'd0;
            2'd1: w_ld_m1 = 10'd7;
            2'd2: w_ld_m1 = 10'd63;
            2'd3: w_ld_m1 = 10'd1023;
        endcase
    end

    always_comb begin
        w_rdata = 8'h00;
        if (!addr[2]) begin
            case (addr[1:0])
                2'd0: w_rdata = w_pa;
                2'd1: w_rdata = r_pa_oe;
                2'd2: w_rdata = w_pb;
                2'd3: w_rdata = r_pb_oe;
            endcase
        end else if (!addr[0]) begin
            w_rdata = r_timer;
        end else begin
            w_rdata = {r_tflag, w_eflag, 6'b000000};
        end
    end

    // Read data follows the CPU clock, not ce, so it is valid for the registered DI input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dout <= 8'h00;
        end else if (cs && !we) begin
            r_dout <= w_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pa_out <= 8'h00;
            r_pa_oe  <= 8'h00;
            r_pb_out <= 8'h00;
            r_pb_oe  <= 8'h00;
        end else if (w_wr && !addr[2]) begin
            case (addr[1:0])
                2'd0: r_pa_out <= din;
                2'd1: r_pa_oe  <= din;
                2'd2: r_pb_out <= din;
                2'd3: r_pb_oe  <= din;
            endcase
        end
    end

    // r_fast latches the post-underflow 1T mode; only a new load leaves it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer   <= RESET_TIMER;
            r_pre     <= 10'd1023;
            r_ivl_m1  <= 10'd1023;
            r_fast    <= 1'b0;
            r_tflag   <= 1'b0;
            r_tirq_en <= 1'b0;
        end else if (w_load) begin
            r_timer   <= din;
            r_pre     <= w_ld_m1;
            r_ivl_m1  <= w_ld_m1;
            r_fast    <= 1'b0;
            r_tflag   <= 1'b0;
            r_tirq_en <= addr[3];
        end else if (ce) begin
            if (w_intim_rd) begin
                r_tflag   <= 1'b0;
                r_tirq_en <= addr[3];
            end
            if (r_pre == 10'd0) begin
                r_timer <= r_timer - 8'd1;
                if (r_timer == 8'd0) begin
                    r_tflag <= 1'b1;
                    r_fast  <= 1'b1;
                    r_pre   <= 10'd0;
                end else begin
                    r_pre <= r_fast ? 10'd0 : r_ivl_m1;
                end
            end else begin
                r_pre <= r_pre - 10'd1;
            end
        end
    end

`ifdef RIOT_PA7_EDGE_EN
    logic r_pa7_prev;
    logic r_eflag;
    logic r_eirq_en;
    logic r_epol;
    logic w_edge;
    logic w_timint_rd;

    assign w_timint_rd = w_rd & addr[2] & addr[0];
    assign w_edge      = r_epol ? (~r_pa7_prev & w_pa[7]) : (r_pa7_prev & ~w_pa[7]);

    // A detected edge outranks a TIMINT read clearing the flag on the same tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pa7_prev <= 1'b0;
            r_eflag    <= 1'b0;
            r_eirq_en  <= 1'b0;
            r_epol     <= 1'b0;
        end else if (ce) begin
            r_pa7_prev <= w_pa[7];
            if (w_wr && addr[2] && !addr[4]) begin
                r_eirq_en <= addr[1];
                r_epol    <= addr[0];
            end
            if (w_timint_rd) r_eflag <= 1'b0;
            if (w_edge)      r_eflag <= 1'b1;
        end
    end

    assign w_eflag   = r_eflag;
    assign w_eirq_en = r_eirq_en;
`else
    assign w_eflag   = 1'b0;
    assign w_eirq_en = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq_n <= 1'b1;
        end else begin
            r_irq_n <= ~((r_tflag & r_tirq_en) | (w_eflag & w_eirq_en));
        end
    end

    assign dout   = r_dout;
    assign pa_out = r_pa_out;
    assign pa_oe  = r_pa_oe;
    assign pb_out = r_pb_out;
    assign pb_oe  = r_pb_oe;
    assign irq_n  = r_irq_n;

endmodule

// File: tb/tb_riot_6532.sv
// tb_riot_6532: vector table for reset/port decode plus directed timer, IRQ, edge and reset sequences.
module tb_riot_6532;
    logic       clk;
    logic       rst_n;
    logic       ce;
    logic       cs;
    logic [4:0] addr;
    logic       we;
    logic [7:0] din;
    logic [7:0] dout;
    logic [7:0] pa_in;
    logic [7:0] pb_in;
    logic [7:0] pa_out;
    logic [7:0] pb_out;
    logic [7:0] pa_oe;
    logic [7:0] pb_oe;
    logic       irq_n;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       we;
        logic [4:0] addr;
        logic [7:0] din;
        logic [7:0] pa;
        logic [7:0] pb;
        logic [7:0] exp;
        string      name;
    } vec_t;

    vec_t vec[$];

    riot_6532 #(.RESET_TIMER(8'h00)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ce     (ce),
        .cs     (cs),
        .addr   (addr),
        .we     (we),
        .din    (din),
        .dout   (dout),
        .pa_in  (pa_in),
        .pb_in  (pb_in),
        .pa_out (pa_out),
        .pb_out (pb_out),
        .pa_oe  (pa_oe),
        .pb_oe  (pb_oe),
        .irq_n  (irq_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic w, input logic [4:0] a, input logic [7:0] d,
                           input logic [7:0] pa, input logic [7:0] pb,
                           input logic [7:0] exp, input string name);
        vec_t v;
        v.we   = w;
        v.addr = a;
        v.din  = d;
        v.pa   = pa;
        v.pb   = pb;
        v.exp  = exp;
        v.name = name;
        vec.push_back(v);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_write(input logic [4:0] a, input logic [7:0] d);
        cs   = 1'b1;
        we   = 1'b1;
        addr = a;
        din  = d;
        @(posedge clk);
        #1;
        cs = 1'b0;
        we = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, output logic [7:0] d);
        cs   = 1'b1;
        we   = 1'b0;
        addr = a;
        @(posedge clk);
        #1;
        d  = dout;
        cs = 1'b0;
    endtask

    initial begin
        logic [7:0] rd;

        add_vec(1'b0, 5'h00, 8'h00, 8'h5A, 8'h3C, 8'h5A, "rst_swcha");
        add_vec(1'b0, 5'h01, 8'h00, 8'h5A, 8'h3C, 8'h00, "rst_swacnt");
        add_vec(1'b0, 5'h02, 8'h00, 8'h5A, 8'h3C, 8'h3C, "rst_swchb");
        add_vec(1'b0, 5'h03, 8'h00, 8'h5A, 8'h3C, 8'h00, "rst_swbcnt");
        add_vec(1'b0, 5'h04, 8'h00, 8'h5A, 8'h3C, 8'h00, "rst_intim4");
        add_vec(1'b0, 5'h05, 8'h00, 8'h5A, 8'h3C, 8'h00, "rst_timint5");
        add_vec(1'b0, 5'h06, 8'h00, 8'h5A, 8'h3C, 8'h00, "rst_intim6");
        add_vec(1'b0, 5'h07, 8'h00, 8'h5A, 8'h3C, 8'h00, "rst_timint7");
        add_vec(1'b1, 5'h01, 8'hF0, 8'h3C, 8'hC3, 8'h00, "wr_swacnt");
        add_vec(1'b1, 5'h00, 8'hA5, 8'h3C, 8'hC3, 8'h00, "wr_swcha");
        add_vec(1'b0, 5'h00, 8'h00, 8'h3C, 8'hC3, 8'hAC, "mix_swcha");
        add_vec(1'b0, 5'h01, 8'h00, 8'h3C, 8'hC3, 8'hF0, "rd_swacnt");
        add_vec(1'b1, 5'h03, 8'h0F, 8'h3C, 8'hC3, 8'h00, "wr_swbcnt");
        add_vec(1'b1, 5'h02, 8'h5A, 8'h3C, 8'hC3, 8'h00, "wr_swchb");
        add_vec(1'b0, 5'h02, 8'h00, 8'h3C, 8'hC3, 8'hCA, "mix_swchb");
        add_vec(1'b0, 5'h03, 8'h00, 8'h3C, 8'hC3, 8'h0F, "rd_swbcnt");
        add_vec(1'b0, 5'h18, 8'h00, 8'h3C, 8'hC3, 8'hAC, "alias_swcha");

        rst_n = 1'b0;
        ce    = 1'b1;
        cs    = 1'b0;
        we    = 1'b0;
        addr  = 5'h00;
        din   = 8'h00;
        pa_in = 8'h5A;
        pb_in = 8'h3C;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("rst_dout", dout, 8'h00);
        check("rst_irq_n", {7'b0, irq_n}, 8'h01);
        check("rst_pa_oe", pa_oe, 8'h00);
        check("rst_pb_out", pb_out, 8'h00);

        for (int i = 0; i < vec.size(); i++) begin
            pa_in = vec[i].pa;
            pb_in = vec[i].pb;
            if (vec[i].we) begin
                do_write(vec[i].addr, vec[i].din);
            end else begin
                do_read(vec[i].addr, rd);
                check(vec[i].name, rd, vec[i].exp);
            end
        end
        check("pa_out", pa_out, 8'hA5);
        check("pa_oe", pa_oe, 8'hF0);
        check("pb_out", pb_out, 8'h5A);
        check("pb_oe", pb_oe, 8'h0F);
        check("ports_irq_n", {7'b0, irq_n}, 8'h01);

        // TIM8T load of 05: ticks counted from the load edge E0.
        do_write(5'h15, 8'h05);
        do_read(5'h04, rd);  check("tim8_e1", rd, 8'h05);
        idle(6);
        do_read(5'h04, rd);  check("tim8_e8", rd, 8'h05);
        do_read(5'h04, rd);  check("tim8_e9", rd, 8'h04);
        idle(38);
        do_read(5'h04, rd);  check("tim8_e48", rd, 8'h00);
        do_read(5'h05, rd);  check("tim8_flag_setwins", rd, 8'h80);
        do_read(5'h04, rd);  check("tim8_fe", rd, 8'hFE);
        do_read(5'h04, rd);  check("tim8_fd", rd, 8'hFD);
        idle(3);
        check("dout_hold", dout, 8'hFD);
        check("tim8_irq_n", {7'b0, irq_n}, 8'h01);

        // TIM1T load of 02 with timer IRQ enabled.
        do_write(5'h1C, 8'h02);
        idle(3);
        check("irq_delay", {7'b0, irq_n}, 8'h01);
        idle(1);
        check("irq_low", {7'b0, irq_n}, 8'h00);
        do_read(5'h05, rd);  check("tim1_timint", rd, 8'h80);
        do_read(5'h04, rd);  check("tim1_intim", rd, 8'hFD);
        check("irq_hold", {7'b0, irq_n}, 8'h00);
        do_read(5'h04, rd);  check("tim1_fast_fc", rd, 8'hFC);
        check("irq_clear", {7'b0, irq_n}, 8'h01);
        do_read(5'h04, rd);  check("tim1_fast_fb", rd, 8'hFB);
        do_read(5'h05, rd);  check("tim1_flag_clr", rd, 8'h00);

        // New load lands on the underflow tick.
        do_write(5'h1C, 8'h01);
        idle(1);
        do_write(5'h15, 8'h33);
        do_read(5'h05, rd);  check("ld_uf_flag", rd, 8'h00);
        do_read(5'h04, rd);  check("ld_uf_intim", rd, 8'h33);
        check("ld_uf_irq_n", {7'b0, irq_n}, 8'h01);

        // Timer frozen while ce is low; dout still loads.
        do_write(5'h14, 8'h20);
        ce = 1'b0;
        idle(5);
        do_read(5'h04, rd);  check("ce_hold", rd, 8'h20);
        ce = 1'b1;
        do_read(5'h04, rd);  check("ce_resume", rd, 8'h20);
        do_read(5'h04, rd);  check("ce_tick", rd, 8'h1F);

        do_write(5'h01, 8'h00);
        do_write(5'h17, 8'hFF);
        do_write(5'h07, 8'h00);
        pa_in = 8'h00;
        idle(2);
        pa_in = 8'h80;
`ifdef RIOT_PA7_EDGE_EN
        idle(2);
        check("edge_irq", {7'b0, irq_n}, 8'h00);
        do_read(5'h05, rd);  check("edge_flag", rd, 8'h40);
        idle(1);
        check("edge_irq_clr", {7'b0, irq_n}, 8'h01);
        pa_in = 8'h00;
        idle(2);
        do_read(5'h05, rd);  check("edge_fall", rd, 8'h00);
        check("edge_fall_irq", {7'b0, irq_n}, 8'h01);
`else
        idle(2);
        check("noedge_irq", {7'b0, irq_n}, 8'h01);
        do_read(5'h05, rd);  check("noedge_flag", rd, 8'h00);
`endif

        // Asynchronous reset in the middle of a count with irq_n asserted.
        do_write(5'h1C, 8'h01);
        idle(3);
        check("pre_rst_irq", {7'b0, irq_n}, 8'h00);
        do_read(5'h04, rd);  check("pre_rst_dout", rd, 8'hFE);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_dout", dout, 8'h00);
        check("async_irq_n", {7'b0, irq_n}, 8'h01);
        check("async_pa_out", pa_out, 8'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_read(5'h04, rd);  check("post_rst_intim", rd, 8'h00);
        do_read(5'h05, rd);  check("post_rst_timint", rd, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
